// File: rtl/dex_hazard_if.sv
// Decode/hazard-control bus: decode-stage instruction fields in, pipeline controls out.
`default_nettype none

interface dex_hazard_if #(
    parameter int REG_ADDR_W = 3
);
    logic                  d_valid;
    logic [REG_ADDR_W-1:0] d_rs;
    logic                  d_rs_used;
    logic [REG_ADDR_W-1:0] d_rt;
    logic                  d_rt_used;
    logic [REG_ADDR_W-1:0] d_rd;
    logic                  d_rd_wr;
    logic                  d_is_load;
    logic                  d_halt;
    logic                  ex_branch_taken;
    logic                  stall;
    logic                  dex_bubble;
    logic                  fd_flush;
    logic                  halted;
    logic [15:0]           stall_count;

    modport master (
        output d_valid, d_rs, d_rs_used, d_rt, d_rt_used, d_rd, d_rd_wr,
               d_is_load, d_halt, ex_branch_taken,
        input  stall, dex_bubble, fd_flush, halted, stall_count
    );

    modport slave (
        input  d_valid, d_rs, d_rs_used, d_rt, d_rt_used, d_rd, d_rd_wr,
               d_is_load, d_halt, ex_branch_taken,
        output stall, dex_bubble, fd_flush, halted, stall_count
    );
endinterface

`default_nettype wire

// File: rtl/dex_hazard_ctrl.sv
//==============================================================================
// Module      : dex_hazard_ctrl
// Description : D/EX issue/bubble/squash control with a 3-slot RAW scoreboard
//               and HALT drain sequencing. Define FORWARD_EN for load-use-only
//               interlock (EX/MEM forwarding present).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module dex_hazard_ctrl #(
    parameter int REG_ADDR_W = 3,
    parameter bit WB_BYPASS  = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    dex_hazard_if.slave  bus
);

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  is_load;
    } slot_t;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    slot_t       r_ex, r_mem, r_wb, w_issue_slot;
    state_t      r_state, w_next_state;
    logic [1:0]  r_drain_cnt, w_next_drain_cnt;
    logic [15:0] r_stall_count;
    logic        w_hazard, w_issue, w_stall, w_bubble, w_flush, w_count_en;
    logic        w_ex_match;

    function automatic logic src_match(
        input slot_t                 s,
        input logic [REG_ADDR_W-1:0] rs,
        input logic                  rs_used,
        input logic [REG_ADDR_W-1:0] rt,
        input logic                  rt_used
    );
        return s.valid & ((rs_used & (rs == s.rd)) | (rt_used & (rt == s.rd)));
    endfunction

    assign w_ex_match = src_match(r_ex, bus.d_rs, bus.d_rs_used, bus.d_rt, bus.d_rt_used);

`ifdef FORWARD_EN
    // Forwarding covers everything except a load result needed one cycle later.
    assign w_hazard = bus.d_valid & w_ex_match & r_ex.is_load;
`else
    logic w_mem_match, w_wb_match;
    assign w_mem_match = src_match(r_mem, bus.d_rs, bus.d_rs_used, bus.d_rt, bus.d_rt_used);
    assign w_wb_match  = src_match(r_wb,  bus.d_rs, bus.d_rs_used, bus.d_rt, bus.d_rt_used);
    assign w_hazard    = bus.d_valid & (w_ex_match | w_mem_match | (~WB_BYPASS & w_wb_match));
`endif

    // Not every slot field feeds the hazard equation in every build.
    logic w_unused;
    assign w_unused = ^{r_ex.is_load, r_mem, r_wb, WB_BYPASS};

    always_comb begin
        w_stall          = 1'b0;
        w_bubble         = 1'b0;
        w_flush          = 1'b0;
        w_count_en       = 1'b0;
        w_issue          = 1'b0;
        w_next_state     = r_state;
        w_next_drain_cnt = r_drain_cnt;

        if (rst) begin
            w_bubble = 1'b1;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (bus.ex_branch_taken) begin
                        w_flush  = 1'b1;
                        w_bubble = 1'b1;
                    end else if (w_hazard) begin
                        w_stall    = 1'b1;
                        w_bubble   = 1'b1;
                        w_count_en = 1'b1;
                    end
                end
                ST_DRAIN: begin
                    w_stall          = 1'b1;
                    w_bubble         = 1'b1;
                    w_next_drain_cnt = r_drain_cnt - 2'd1;
                    if (r_drain_cnt == 2'd1) begin
                        w_next_state = ST_HALTED;
                    end
                end
                ST_HALTED: begin
                    w_stall  = 1'b1;
                    w_bubble = 1'b1;
                end
                default: begin
                    w_next_state = ST_RUN;
                end
            endcase

            w_issue = bus.d_valid & ~w_stall & ~w_flush & (r_state == ST_RUN);
            if (w_issue & bus.d_halt) begin
                w_next_state     = ST_DRAIN;
                w_next_drain_cnt = 2'd3;
            end
        end
    end

    always_comb begin
        w_issue_slot         = '0;
        w_issue_slot.valid   = w_issue & bus.d_rd_wr;
        w_issue_slot.rd      = bus.d_rd;
        w_issue_slot.is_load = bus.d_is_load;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex          <= '0;
            r_mem         <= '0;
            r_wb          <= '0;
            r_state       <= ST_RUN;
            r_drain_cnt   <= 2'd0;
            r_stall_count <= 16'd0;
        end else begin
            r_ex        <= w_issue_slot;
            r_mem       <= r_ex;
            r_wb        <= r_mem;
            r_state     <= w_next_state;
            r_drain_cnt <= w_next_drain_cnt;
            if (w_count_en && (r_stall_count != 16'hFFFF)) begin
                r_stall_count <= r_stall_count + 16'd1;
            end
        end
    end

    assign bus.stall       = w_stall;
    assign bus.dex_bubble  = w_bubble;
    assign bus.fd_flush    = w_flush;
    assign bus.halted      = ~rst & (r_state == ST_HALTED);
    assign bus.stall_count = r_stall_count;

endmodule

`default_nettype wire

// File: tb/tb_dex_hazard_ctrl.sv
// Scoreboard bench for dex_hazard_ctrl: instance A (WB_BYPASS=1) runs directed and
// random traffic, instance B (WB_BYPASS=0) runs a back-to-back dependency chain.
`default_nettype none

module tb_dex_hazard_ctrl;

    logic clk = 1'b0;
    logic rst_a, rst_b;
    always #5 clk = ~clk;

    dex_hazard_if #(.REG_ADDR_W(3)) ifa ();
    dex_hazard_if #(.REG_ADDR_W(3)) ifb ();

    dex_hazard_ctrl #(.REG_ADDR_W(3), .WB_BYPASS(1'b1)) u_a (.clk(clk), .rst(rst_a), .bus(ifa.slave));
    dex_hazard_ctrl #(.REG_ADDR_W(3), .WB_BYPASS(1'b0)) u_b (.clk(clk), .rst(rst_b), .bus(ifb.slave));

    typedef struct packed {
        logic       rst, valid;
        logic [2:0] rs;
        logic       rs_used;
        logic [2:0] rt;
        logic       rt_used;
        logic [2:0] rd;
        logic       rd_wr, load, halt, br;
    } in_t;

    typedef struct packed {
        logic        stall, bubble, flush, halted;
        logic [15:0] cnt;
        logic        chk_cnt, issued;
    } exp_t;

`ifdef FORWARD_EN
    localparam int SAT_CYC = 2000;
`else
    localparam int SAT_CYC = 87400;
`endif

    int   checks = 0;
    int   errors = 0;
    exp_t qa[$];
    exp_t qb[$];

    // Reference model: a register is unavailable while its most recent writer
    // issued no more than 'win' cycles ago (1 = EX, 2 = MEM, 3 = WB).
    int m_cyc[2];
    int m_lastw[2][8];
    bit m_ld[2][8];
    int m_mode[2];   // 0 run, 1 drain, 2 halted
    int m_n[2];
    int m_cnt[2];

    function automatic bit src_hit(int k, int win, logic [2:0] r);
        int d;
        d = m_cyc[k] - m_lastw[k][r];
`ifdef FORWARD_EN
        return (d == 1) && m_ld[k][r];
`else
        return (d >= 1) && (d <= win);
`endif
    endfunction

    function automatic exp_t model_step(int k, int win, in_t x);
        exp_t e;
        bit   haz;
        e = '0;
        e.cnt = m_cnt[k][15:0];
        e.chk_cnt = !x.rst;
        if (x.rst) begin
            e.bubble = 1'b1;
            m_mode[k] = 0;
            m_cnt[k] = 0;
            for (int r = 0; r < 8; r++) m_lastw[k][r] = -100;
        end else if (m_mode[k] == 2) begin
            e.stall = 1'b1; e.bubble = 1'b1; e.halted = 1'b1;
        end else if (m_mode[k] == 1) begin
            e.stall = 1'b1; e.bubble = 1'b1;
            m_n[k]--;
            if (m_n[k] == 0) m_mode[k] = 2;
        end else begin
            haz = x.valid && ((x.rs_used && src_hit(k, win, x.rs)) ||
                              (x.rt_used && src_hit(k, win, x.rt)));
            if (x.br) begin
                e.flush = 1'b1; e.bubble = 1'b1;
            end else if (haz) begin
                e.stall = 1'b1; e.bubble = 1'b1;
                if (m_cnt[k] < 65535) m_cnt[k]++;
            end else if (x.valid) begin
                e.issued = 1'b1;
                if (x.rd_wr) begin
                    m_lastw[k][x.rd] = m_cyc[k];
                    m_ld[k][x.rd] = x.load;
                end
                if (x.halt) begin
                    m_mode[k] = 1;
                    m_n[k] = 3;
                end
            end
        end
        m_cyc[k]++;
        return e;
    endfunction

    function automatic in_t idle_in();
        in_t x;
        x = '0;
        return x;
    endfunction

    function automatic in_t mk(logic [2:0] rs, logic rsu, logic [2:0] rt, logic rtu,
                               logic [2:0] rd, logic wr, logic ld, logic hlt, logic br);
        in_t x;
        x = '0;
        x.valid = 1'b1; x.rs = rs; x.rs_used = rsu; x.rt = rt; x.rt_used = rtu;
        x.rd = rd; x.rd_wr = wr; x.load = ld; x.halt = hlt; x.br = br;
        return x;
    endfunction

    function automatic in_t rand_in();
        in_t x;
        x = in_t'($urandom);
        x.rst  = 1'b0;
        x.halt = 1'b0;
        x.br   = ($urandom_range(0, 7) == 0);
        return x;
    endfunction

    task automatic drive_a(input in_t x, output bit issued);
        exp_t e;
        @(posedge clk); #1;
        rst_a = x.rst; ifa.d_valid = x.valid; ifa.d_rs = x.rs; ifa.d_rs_used = x.rs_used;
        ifa.d_rt = x.rt; ifa.d_rt_used = x.rt_used; ifa.d_rd = x.rd; ifa.d_rd_wr = x.rd_wr;
        ifa.d_is_load = x.load; ifa.d_halt = x.halt; ifa.ex_branch_taken = x.br;
        e = model_step(0, 2, x);
        qa.push_back(e);
        issued = e.issued;
    endtask

    task automatic drive_b(input in_t x, output bit issued);
        exp_t e;
        @(posedge clk); #1;
        rst_b = x.rst; ifb.d_valid = x.valid; ifb.d_rs = x.rs; ifb.d_rs_used = x.rs_used;
        ifb.d_rt = x.rt; ifb.d_rt_used = x.rt_used; ifb.d_rd = x.rd; ifb.d_rd_wr = x.rd_wr;
        ifb.d_is_load = x.load; ifb.d_halt = x.halt; ifb.ex_branch_taken = x.br;
        e = model_step(1, 3, x);
        qb.push_back(e);
        issued = e.issued;
    endtask

    // Hold an instruction in decode until the model says it issues.
    task automatic issue_a(input in_t x, input string tag);
        bit iss;
        for (int i = 0; i < 8; i++) begin
            drive_a(x, iss);
            if (iss) return;
        end
        errors++;
        $display("FAIL %s: instruction not issued within 8 cycles (required issue)", tag);
    endtask

    task automatic cmp(string n, logic s, logic b, logic f, logic h, logic [15:0] c, exp_t e);
        checks += 4;
        if (s !== e.stall)  begin errors++; $display("FAIL %s.stall t=%0t: got %b exp %b", n, $time, s, e.stall); end
        if (b !== e.bubble) begin errors++; $display("FAIL %s.dex_bubble t=%0t: got %b exp %b", n, $time, b, e.bubble); end
        if (f !== e.flush)  begin errors++; $display("FAIL %s.fd_flush t=%0t: got %b exp %b", n, $time, f, e.flush); end
        if (h !== e.halted) begin errors++; $display("FAIL %s.halted t=%0t: got %b exp %b", n, $time, h, e.halted); end
        if (e.chk_cnt) begin
            checks++;
            if (c !== e.cnt) begin errors++; $display("FAIL %s.stall_count t=%0t: got %0d exp %0d", n, $time, c, e.cnt); end
        end
    endtask

    initial begin : mon_a
        exp_t e;
        forever begin
            @(negedge clk);
            if (qa.size() != 0) begin
                e = qa.pop_front();
                cmp("A", ifa.stall, ifa.dex_bubble, ifa.fd_flush, ifa.halted, ifa.stall_count, e);
            end
        end
    end

    initial begin : mon_b
        exp_t e;
        forever begin
            @(negedge clk);
            if (qb.size() != 0) begin
                e = qb.pop_front();
                cmp("B", ifb.stall, ifb.dex_bubble, ifb.fd_flush, ifb.halted, ifb.stall_count, e);
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic run_a();
        bit   iss;
        in_t  x;
        x = idle_in(); x.rst = 1'b1;
        repeat (2) drive_a(x, iss);
        // no dependencies
        repeat (4) drive_a(mk(3'($urandom), 1'b1, 3'($urandom), 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0), iss);
        // ALU producer then dependent consumer
        issue_a(mk(3'd0, 1'b0, 3'd0, 1'b0, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0), "add_r3");
        issue_a(mk(3'd3, 1'b1, 3'd1, 1'b0, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0), "sub_r3");
        repeat (3) drive_a(idle_in(), iss);
        // load producer then rt consumer
        issue_a(mk(3'd0, 1'b0, 3'd0, 1'b0, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0), "ld_r2");
        issue_a(mk(3'd6, 1'b1, 3'd2, 1'b1, 3'd7, 1'b1, 1'b0, 1'b0, 1'b0), "use_r2");
        repeat (3) drive_a(idle_in(), iss);
        // hazard coincides with a taken branch: squashed rd6 must not be tracked
        issue_a(mk(3'd0, 1'b0, 3'd0, 1'b0, 3'd5, 1'b1, 1'b1, 1'b0, 1'b0), "ld_r5");
        drive_a(mk(3'd5, 1'b1, 3'd0, 1'b0, 3'd6, 1'b1, 1'b0, 1'b0, 1'b1), iss);
        repeat (3) drive_a(idle_in(), iss);
        drive_a(mk(3'd6, 1'b1, 3'd6, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0), iss);
        // random traffic
        for (int i = 0; i < 400; i++) drive_a(rand_in(), iss);
        // hazard-stalled HALT, drain, halted, reset
        issue_a(mk(3'd0, 1'b0, 3'd0, 1'b0, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0), "pre_halt");
        issue_a(mk(3'd4, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0), "halt");
        for (int i = 0; i < 8; i++) drive_a(rand_in(), iss);
        x = idle_in(); x.rst = 1'b1;
        drive_a(x, iss);
        repeat (3) drive_a(rand_in(), iss);
        // reset in the middle of a drain
        issue_a(mk(3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0), "halt2");
        drive_a(idle_in(), iss);
        drive_a(x, iss);
        for (int i = 0; i < 20; i++) drive_a(rand_in(), iss);
    endtask

    task automatic run_b();
        bit  iss;
        in_t x;
        x = idle_in(); x.rst = 1'b1;
        repeat (2) drive_b(x, iss);
        // each instruction reads and rewrites r1, so every one waits on its predecessor
        for (int i = 0; i < SAT_CYC; i++)
            drive_b(mk(3'd1, 1'b1, 3'd1, 1'b0, 3'd1, 1'b1, 1'b1, 1'b0, 1'b0), iss);
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        ifa.d_valid = 1'b0; ifa.d_rs = '0; ifa.d_rs_used = 1'b0; ifa.d_rt = '0; ifa.d_rt_used = 1'b0;
        ifa.d_rd = '0; ifa.d_rd_wr = 1'b0; ifa.d_is_load = 1'b0; ifa.d_halt = 1'b0; ifa.ex_branch_taken = 1'b0;
        ifb.d_valid = 1'b0; ifb.d_rs = '0; ifb.d_rs_used = 1'b0; ifb.d_rt = '0; ifb.d_rt_used = 1'b0;
        ifb.d_rd = '0; ifb.d_rd_wr = 1'b0; ifb.d_is_load = 1'b0; ifb.d_halt = 1'b0; ifb.ex_branch_taken = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m_cyc[k] = 0; m_mode[k] = 0; m_n[k] = 0; m_cnt[k] = 0;
            for (int r = 0; r < 8; r++) begin m_lastw[k][r] = -100; m_ld[k][r] = 1'b0; end
        end
        fork
            run_a();
            run_b();
        join
        repeat (2) @(negedge clk);
        checks++;
        if (qa.size() + qb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected responses left unchecked (required 0)", qa.size() + qb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
